// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared decoder constants, register/writeback codes and control FSM state encoding
package cpu_pkg;

    localparam logic [2:0] OPC_MOV      = 3'b110;
    localparam logic [2:0] OPC_ALU      = 3'b101;

    localparam logic [1:0] OP_MOV_IMM   = 2'b10;
    localparam logic [1:0] OP_MOV_SHIFT = 2'b00;
    localparam logic [1:0] OP_ADD       = 2'b00;
    localparam logic [1:0] OP_CMP       = 2'b01;
    localparam logic [1:0] OP_AND       = 2'b10;
    localparam logic [1:0] OP_MVN       = 2'b11;

    localparam logic [2:0] NSEL_RN      = 3'b000;
    localparam logic [2:0] NSEL_RD      = 3'b001;
    localparam logic [2:0] NSEL_RM      = 3'b010;

    localparam logic [1:0] VSEL_C       = 2'b00;
    localparam logic [1:0] VSEL_SXIMM8  = 2'b10;

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_EXEC      = 3'd5,
        S_WRITE_REG = 3'd6,
        S_ERROR     = 3'd7
    } state_t;

    // Flavour of the EXEC step, captured in DECODE so EXEC outputs depend only on registers.
    typedef enum logic [1:0] {
        EX_ALU    = 2'd0,
        EX_ZERO_A = 2'd1,
        EX_CMP    = 2'd2
    } exec_t;

endpackage

// File: rtl/risc_ctrl_outputs.sv
// rtl/risc_ctrl_outputs.sv - state -> datapath control vector decode; err output only with CTRL_ILLEGAL_TRAP_EN
module risc_ctrl_outputs
    import cpu_pkg::*;
(
    input  state_t      state_i,
    input  exec_t       kind_i,
    output logic        w_o,
    output logic [2:0]  nsel_o,
    output logic [1:0]  vsel_o,
    output logic        write_o,
    output logic        loada_o,
    output logic        loadb_o,
    output logic        asel_o,
    output logic        bsel_o,
    output logic        loadc_o,
    output logic        loads_o
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic        err_o
`endif
);

    always_comb begin
        w_o     = 1'b0;
        nsel_o  = NSEL_RN;
        vsel_o  = VSEL_C;
        write_o = 1'b0;
        loada_o = 1'b0;
        loadb_o = 1'b0;
        asel_o  = 1'b0;
        bsel_o  = 1'b0;
        loadc_o = 1'b0;
        loads_o = 1'b0;
        case (state_i)
            S_WAIT:      w_o = 1'b1;
            S_WRITE_IMM: begin
                nsel_o  = NSEL_RN;
                vsel_o  = VSEL_SXIMM8;
                write_o = 1'b1;
            end
            S_GET_A: begin
                nsel_o  = NSEL_RN;
                loada_o = 1'b1;
            end
            S_GET_B: begin
                nsel_o  = NSEL_RM;
                loadb_o = 1'b1;
            end
            S_EXEC: begin
                loadc_o = 1'b1;
                asel_o  = (kind_i == EX_ZERO_A);
                loads_o = (kind_i == EX_CMP);
            end
            S_WRITE_REG: begin
                nsel_o  = NSEL_RD;
                vsel_o  = VSEL_C;
                write_o = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign err_o = (state_i == S_ERROR);
`endif

endmodule

// File: rtl/risc_control_fsm.sv
// rtl/risc_control_fsm.sv - Moore sequencer for the 5-step RISC datapath; CTRL_ILLEGAL_TRAP_EN adds a sticky ERROR state
module risc_control_fsm
    import cpu_pkg::*;
#(
    parameter int STATE_W = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic [2:0]  opcode,
    input  logic [1:0]  op,
    output logic        w,
    output logic [2:0]  nsel,
    output logic [1:0]  vsel,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        asel,
    output logic        bsel,
    output logic        loadc,
    output logic        loads
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic        err
`endif
);

    logic [STATE_W-1:0] state_q;
    state_t             state_d;
    state_t             cur;
    exec_t              kind_q, kind_d;

    assign cur = state_t'(state_q);

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam state_t ILLEGAL_NEXT = S_ERROR;
`else
    localparam state_t ILLEGAL_NEXT = S_WAIT;
`endif

    always_comb begin
        state_d = cur;
        kind_d  = kind_q;
        case (cur)
            S_WAIT:      if (s) state_d = S_DECODE;
            S_DECODE: begin
                state_d = ILLEGAL_NEXT;
                if (opcode == OPC_MOV && op == OP_MOV_IMM) begin
                    state_d = S_WRITE_IMM;
                end else if (opcode == OPC_MOV && op == OP_MOV_SHIFT) begin
                    state_d = S_GET_B;
                    kind_d  = EX_ZERO_A;
                end else if (opcode == OPC_ALU) begin
                    case (op)
                        OP_ADD, OP_AND: begin
                            state_d = S_GET_A;
                            kind_d  = EX_ALU;
                        end
                        OP_CMP: begin
                            state_d = S_GET_A;
                            kind_d  = EX_CMP;
                        end
                        default: begin
                            state_d = S_GET_B;
                            kind_d  = EX_ZERO_A;
                        end
                    endcase
                end
            end
            S_WRITE_IMM: state_d = S_WAIT;
            S_GET_A:     state_d = S_GET_B;
            S_GET_B:     state_d = S_EXEC;
            S_EXEC:      state_d = (kind_q == EX_CMP) ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: state_d = S_WAIT;
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_ERROR:     state_d = S_ERROR;
`endif
            default:     state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_WAIT;
            kind_q  <= EX_ALU;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
        end
    end

    risc_ctrl_outputs u_outputs (
        .state_i (cur),
        .kind_i  (kind_q),
        .w_o     (w),
        .nsel_o  (nsel),
        .vsel_o  (vsel),
        .write_o (write),
        .loada_o (loada),
        .loadb_o (loadb),
        .asel_o  (asel),
        .bsel_o  (bsel),
        .loadc_o (loadc),
        .loads_o (loads)
`ifdef CTRL_ILLEGAL_TRAP_EN
        ,
        .err_o   (err)
`endif
    );

endmodule

// File: doc/risc_control_fsm.md
Name: risc_control_fsm

Overview:
- Moore state machine that sequences the 5-step RISC datapath for one instruction at a time.
- Takes opcode/op from the instruction decoder and a start strobe.
- Drives register-file select/write, A/B/C/status load enables and operand muxes through read, execute and writeback.
- Sits between the instruction register/decoder and the datapath; `w` tells the top level it is idle.

Parameters:
- STATE_W, 3, width of the state register (7 states, 8 with the optional feature).

Ports:
- clk  input  1  single clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high reset; forces WAIT at the next clk edge
- s  input  1  start strobe; sampled only in WAIT
- opcode  input  3  instruction opcode from decoder (110 = MOV, 101 = ALU)
- op  input  2  sub-op from decoder
- w  output  1  1 = idle in WAIT, ready for s
- nsel  output  3  register select: 000 = Rn, 001 = Rd, 010 = Rm
- vsel  output  2  writeback source: 00 = C (ALU result), 10 = sximm8
- write  output  1  register-file write enable
- loada  output  1  load A register
- loadb  output  1  load B register
- asel  output  1  1 = ALU A operand forced to 0
- bsel  output  1  1 = ALU B operand is sximm5 (held 0 by this block)
- loadc  output  1  load C register
- loads  output  1  load status flags
- err  output  1  illegal-instruction flag; present only with the optional feature

Behaviour:
- All outputs are pure functions of the state register (Moore).
  - Strobes not listed for a state are 0.
  - nsel and vsel are 000/00 unless listed.
- Reset:
  - state = WAIT at the next edge, including mid-instruction.
  - Outputs then: w = 1, all other outputs 0.
- opcode/op are held stable by the instruction register while the FSM is not in WAIT; they are sampled only in DECODE.
- States and outputs:
  - WAIT: w = 1. If s = 1, next state is DECODE; otherwise stay. s is ignored in every other state.
  - DECODE: no strobes. Next state:
    - MOV op = 10 -> WRITE_IMM
    - MOV op = 00 -> GET_B
    - ALU op = 11 (MVN) -> GET_B
    - ALU op = 00, 01 or 10 -> GET_A
    - anything else -> WAIT (see Optional Feature)
  - WRITE_IMM: nsel = Rn, vsel = 10, write = 1. Next state WAIT.
  - GET_A: nsel = Rn, loada = 1. Next state GET_B.
  - GET_B: nsel = Rm, loadb = 1. Next state EXEC.
  - EXEC: loadc = 1.
    - asel = 1 when the instruction is MOV-shift or MVN.
    - loads = 1 only for CMP (ALU op = 01).
    - CMP -> WAIT; all others -> WRITE_REG.
  - WRITE_REG: nsel = Rd, vsel = 00, write = 1. Next state WAIT.
- Latency, counted in edges from the s-sampling edge until back in WAIT (w = 1):
  - MOV imm: 3
  - CMP: 5
  - MOV shift / MVN: 5
  - ADD / AND: 6
- s held high continuously: a new instruction starts on the first edge back in WAIT; no extra idle cycle.
- write is never asserted in the same state as loada/loadb/loadc.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - Unsupported opcode/op in DECODE -> ERROR state.
  - ERROR: err = 1, w = 0, all strobes 0, no exit except reset.
- Undefined:
  - Unsupported encodings return to WAIT with no strobes (no-op).
  - No ERROR state; err port absent.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants (MOV = 110, ALU = 101)
  - op constants (imm = 10, shift = 00, ADD/CMP/AND/MVN = 00/01/10/11)
  - nsel codes (Rn/Rd/Rm) and vsel codes (C/sximm8)
  - state enumeration
- These replace the decoder's local defines.
- One natural sub-module: risc_ctrl_outputs, a combinational state -> output-vector decode. Keeping it separate lets the output table be reviewed in isolation.
- Next-state logic and the state register stay in risc_control_fsm.

Test Plan:
- Reset mid-ADD (assert reset while in GET_B) -> next edge: w = 1, all strobes 0; s = 1 afterwards starts a fresh instruction.
- MOV imm (opcode 110, op 10), s pulsed 1 cycle:
  - Expected sequence: DECODE, WRITE_IMM (nsel 000, vsel 10, write 1), WAIT.
  - w returns to 1 exactly 3 edges after the s edge.
- ADD (101/00):
  - loada with nsel 000, loadb with nsel 010, loadc with asel 0, write with nsel 001 vsel 00, in consecutive cycles.
  - 6 edges total; loads never 1.
- CMP (101/01): loads = 1 and loadc = 1 in EXEC; write never asserted; back to WAIT after 5 edges.
- MVN (101/11) and MOV shift (110/00):
  - GET_A skipped; asel = 1 in EXEC; write with nsel 001.
  - s held high -> second instruction's DECODE follows the WAIT cycle immediately.
- Illegal opcode 111, s = 1:
  - With CTRL_ILLEGAL_TRAP_EN: err = 1 from the edge after DECODE, stuck until reset.
  - Without it: back in WAIT after 2 edges, no strobes ever asserted.
